// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the state encoding for the integer-power sequencer.
// Imported by the controller and by anything that drives the shared multiplier.
package fp32_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHK     = 3'd1,
    ISSUE_R = 3'd2,
    WAIT_R  = 3'd3,
    ISSUE_S = 3'd4,
    WAIT_S  = 3'd5,
    FIN     = 3'd6
  } pow_state_e;

endpackage

// File: rtl/fp_pow_int_ctrl.sv
// Right-to-left square-and-multiply sequencer computing base^n (FP32 base, unsigned n).
// Every multiply is issued over req/ack to one shared external FP32 multiplier.
module fp_pow_int_ctrl
  import fp32_pkg::*;
#(
  parameter int          N_W    = 8,
  parameter logic [31:0] ONE_FP = FP_ONE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [31:0]    base,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic [31:0]    out,
  output logic [3:0]     mul_cnt,
  output logic           mul_req,
  output logic [31:0]    mul_a,
  output logic [31:0]    mul_b,
  input  logic           mul_ack,
  input  logic [31:0]    mul_res
);

  pow_state_e     state_q, state_d;
  logic [31:0]    r_q, r_d;
  logic [31:0]    s_q, s_d;
  logic [N_W-1:0] e_q, e_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [31:0]    out_q, out_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           req_q, req_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;

  logic           e_gt_one;

  assign e_gt_one = (e_q > N_W'(1));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = ONE_FP;
          s_d     = base;
          e_d     = n;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = (n == '0) ? FIN : CHK;
        end
      end

      CHK: begin
        if (e_q[0]) begin
          state_d = ISSUE_R;
        end else if (e_gt_one) begin
          state_d = ISSUE_S;
        end else begin
          state_d = FIN;
        end
      end

      ISSUE_R: begin
        req_d   = 1'b1;
        a_d     = r_q;
        b_d     = s_q;
        cnt_d   = cnt_q + 4'd1;
        state_d = WAIT_R;
      end

      // Once the result absorbs its factor, the last bit skips CHK; the
      // trailing square would be wasted so it is never issued.
      WAIT_R: begin
        if (mul_ack) begin
          r_d   = mul_res;
          req_d = 1'b0;
          if (e_gt_one) begin
            state_d = ISSUE_S;
          end else begin
            e_d     = e_q >> 1;
            state_d = FIN;
          end
        end
      end

      ISSUE_S: begin
        req_d   = 1'b1;
        a_d     = s_q;
        b_d     = s_q;
        cnt_d   = cnt_q + 4'd1;
        state_d = WAIT_S;
      end

      WAIT_S: begin
        if (mul_ack) begin
          s_d     = mul_res;
          e_d     = e_q >> 1;
          req_d   = 1'b0;
          state_d = CHK;
        end
      end

      FIN: begin
        out_d   = r_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= FP_ZERO;
      s_q     <= FP_ZERO;
      e_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= FP_ZERO;
      cnt_q   <= 4'd0;
      req_q   <= 1'b0;
      a_q     <= FP_ZERO;
      b_q     <= FP_ZERO;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign out     = out_q;
  assign mul_cnt = cnt_q;
  assign mul_req = req_q;
  assign mul_a   = a_q;
  assign mul_b   = b_q;

endmodule

// File: doc/fp_pow_int_ctrl.md
Name: fp_pow_int_ctrl

Overview:
Sequencer that computes out = base^n, where base is IEEE-754 single-precision and n is an unsigned integer. It uses right-to-left square-and-multiply. All multiplies go through one shared external FP32 multiplier over a req/ack handshake. It is the iterative front-end that drives the team's FP multiply datapath for integer-exponent powers, complementing the real-exponent power block.

Parameters:
N_W, 8, width of integer exponent n
ONE_FP, 32'h3F800000, IEEE-754 encoding of 1.0 used as the result seed

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
base  in  32  FP32 base; captured on accepted start
n  in  N_W  unsigned exponent; captured on accepted start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when out is valid
out  out  32  FP32 result; held until the next accepted start
mul_cnt  out  4  number of multiplies issued for the last operation
mul_req  out  1  multiply request to the shared multiplier
mul_a  out  32  multiplier operand A
mul_b  out  32  multiplier operand B
mul_ack  in  1  one-cycle pulse: mul_res is valid, request complete
mul_res  in  32  multiplier product

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, out=0, mul_cnt=0, mul_req=0, mul_a=0, mul_b=0.
- Internal registers: R (result, FP32), S (square, FP32), E (remaining exponent, N_W bits).
- IDLE:
  - On start=1, load R=ONE_FP, S=base, E=n, mul_cnt=0.
  - If n==0, go to FIN. Otherwise go to CHK.
- CHK (one cycle, decision only):
  - If E[0]=1, go to ISSUE_R.
  - Else if E>1, go to ISSUE_S.
  - Else (E==0 after shift), go to FIN.
- ISSUE_R: mul_req=1, mul_a=R, mul_b=S, mul_cnt++. Go to WAIT_R.
- WAIT_R:
  - Hold mul_req, mul_a and mul_b stable until mul_ack.
  - On mul_ack: R=mul_res, drop mul_req the same edge.
  - Then, if E>1 go to ISSUE_S; else set E=E>>1 and go to FIN.
- ISSUE_S: mul_req=1, mul_a=S, mul_b=S, mul_cnt++. Go to WAIT_S.
- WAIT_S: on mul_ack: S=mul_res, E=E>>1, drop mul_req, go to CHK.
- FIN: out=R, done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- The final square is never issued: squaring happens only while E>1.
- Total multiplies = popcount(n) + floor(log2 n) for n≥1. Maximum for N_W=8 is 15, so mul_cnt fits in 4 bits.
- Latency for n=0 is start + 2 cycles (IDLE→FIN→done).
- Otherwise latency is 2 + per-multiply (2 + ack wait) + per-CHK visits; it is data-dependent.
- Boundary conditions:
  - start while busy: ignored; no effect on R, S, E or outputs.
  - mul_ack outside WAIT_R/WAIT_S: ignored.
  - mul_ack in the same cycle as entering WAIT_*: not possible. The ack is only valid from the cycle after mul_req rises.
  - Reset mid-operation: immediate return to IDLE, mul_req=0. The external multiplier must tolerate an abandoned request.
  - NaN, Inf and zero bases: no special-casing. Results follow the multiplier's IEEE behaviour, except n==0, which returns ONE_FP for any base, including NaN.
  - Rounding: each multiply rounds per the multiplier. Results are exact only when all intermediates are representable.

Decomposition:
- Shared package fp32_pkg holds:
  - constants FP_ONE=32'h3F800000, FP_ZERO, FP_QNAN;
  - the state enum for this controller (IDLE, CHK, ISSUE_R, WAIT_R, ISSUE_S, WAIT_S, FIN).
- No sub-module is needed inside the controller; the multiplier stays external so it can be shared or arbitrated.
- The testbench wraps the team's FP32 multiplier in a variable-latency ack model (fp_mul_ack_model).

Test Plan:
- base=0x40000000 (2.0), n=10, ack latency 1 → out=0x44800000 (1024.0), mul_cnt=5, single done pulse.
- base=0x40400000 (3.0), n=5, ack latency random 1-6 → out=0x43730000 (243.0), mul_cnt=4, operands stable across every wait.
- base=0x7FC00000 (NaN), n=0 → out=0x3F800000, done two cycles after start, mul_req never asserted, mul_cnt=0.
- base=0x3FC00000 (1.5), n=2; a second start pulse asserted while busy → out=0x40100000 (2.25) from the first operation only, mul_cnt=2.
- base=0x40000000, n=255, rst_n dropped during WAIT_S → all outputs return to reset values asynchronously. A new start after release with n=1 → out=0x40000000, mul_cnt=1.
